lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Parametrised multi-cycle load/store controller for the RV32 core's data path.
- Accepts one load or store per handshake from the execute stage.
- Requests in the scratchpad window are served by an internal synchronous SPM; all others go to an external memory port with valid/ready request and valid response.
- Adds lane alignment, misalignment/illegal detection and a bus timeout.

Parameters:
SPM_BASE, 32'h80008000, byte base address of the scratchpad window
SPM_DEPTH, 1024, scratchpad depth in 32-bit words (power of 2, ≥2)
TIMEOUT_CYCLES, 255, max cycles in MEM_REQ+MEM_WAIT before bus fault (≥1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  controller can accept (high only in IDLE)
req_addr  in  32  byte address
req_load  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 111 none)
req_store  in  3  store funct3 (000 SB, 001 SH, 010 SW, 111 none)
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores/faults
resp_fault  out  2  00 ok, 01 misaligned, 10 bus error/timeout, 11 illegal
busy  out  1  state != IDLE
mem_req_valid  out  1  external request valid
mem_req_ready  in  1  external accepts
mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_req_we  out  1  1 = write
mem_req_wdata  out  32  lane-aligned store data
mem_req_wmask  out  4  byte enables (0000 on reads)
mem_resp_valid  in  1  external response valid
mem_resp_rdata  in  32  external read word
mem_resp_err  in  1  external error, qualified by mem_resp_valid

Behaviour:
- Reset (async, any state): state=IDLE; timeout counter=0; all outputs 0 except req_ready=1. Any pending external transaction is abandoned. SPM contents are not reset; simulation initial value is 0.
- States: IDLE, SPM_RD, MEM_REQ, MEM_WAIT, RESP.
- Accept = req_valid & req_ready. Request fields are registered at accept.
- Classification at accept, first match wins:
  - Both load and store ≠111, or unlisted encoding → illegal (11).
  - Both 111 → NOP, fault 00.
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0 → misaligned (01).
  - Otherwise SPM if SPM_BASE ≤ addr < SPM_BASE+4*SPM_DEPTH; else external.
- Illegal, misaligned or NOP: go to RESP. No memory side effects.
- SPM store: merge under wmask into word (addr-SPM_BASE)>>2 at the accept edge, then go to RESP.
- SPM load: synchronous read at the accept edge, then SPM_RD, then RESP.
- Result: resp_valid fires exactly 1 cycle after accept for fault/NOP/SPM store, and 2 cycles after for SPM load.
- External access:
  - MEM_REQ: mem_req_valid=1 with addr/we/wdata/wmask held stable until mem_req_ready.
  - Then MEM_WAIT. mem_resp_valid is sampled only in MEM_WAIT; it is ignored in all other states.
  - On response go to RESP; fault 10 if mem_resp_err.
  - Timeout counter clears at accept and increments each cycle in MEM_REQ/MEM_WAIT. When it reaches TIMEOUT_CYCLES: go to RESP with fault 10 and drop mem_req_valid.
- Store lanes:
  - SB: wdata byte replicated to all lanes, wmask=0001<<addr[1:0].
  - SH: half replicated, wmask=0011<<addr[1:0].
  - SW: wmask=1111.
- Load extraction: select byte addr[1:0] or half addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RESP: resp_valid=1 for exactly one cycle with registered rdata/fault, then IDLE. There is no response backpressure; the earliest next accept is the cycle after RESP.
- busy and !req_ready are equivalent.

Test Plan:
- SW 0xDEADBEEF @0x80008010, then LW same → resp 1 cycle after store accept, 2 after load accept; rdata=DEADBEEF, fault 00, mem_req_valid never asserted.
- SB 0x80 @0x80008013 over word 0, then LB/LBU @0x80008013 → wmask 1000; rdata FFFFFF80 / 00000080; LHU @0x80008012 → 00008000.
- LW @0x80000004, mem_req_ready held low 3 cycles, then response 0x12345678 two cycles later → request fields stable while stalled; resp_valid the cycle after mem_resp_valid, rdata 12345678.
- LH @0x80000001 → fault 01, no mem_req_valid; load=010 & store=010 → fault 11; load=011 → fault 11.
- External LW, no response, TIMEOUT_CYCLES=8 → resp fault 10 after 8 cycles in MEM_REQ/MEM_WAIT; late mem_resp_valid in IDLE ignored. External load with mem_resp_err=1 → fault 10.
- Assert rst during MEM_WAIT → immediately IDLE, req_ready=1, mem_req_valid=0, no resp_valid; next SPM load completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32 load/store controller with scratchpad and external memory port
// Requests are classified at accept; the SPM window is served locally, everything else over valid/ready.
module lsu_mem_ctrl #(
    parameter logic [31:0] SPM_BASE       = 32'h8000_8000,
    parameter int          SPM_DEPTH      = 1024,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [2:0]  i_req_load,
    input  logic [2:0]  i_req_store,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic [1:0]  o_resp_fault,
    output logic        o_busy,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    output logic        o_mem_req_we,
    output logic [31:0] o_mem_req_wdata,
    output logic [3:0]  o_mem_req_wmask,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_resp_rdata,
    input  logic        i_mem_resp_err
);
    localparam int            AW        = $clog2(SPM_DEPTH);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0]   SPM_BYTES = 32'(4 * SPM_DEPTH);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SPM_RD, MEM_REQ, MEM_WAIT, RESP} state_t;
    state_t r_state, w_next;

    logic [31:0]   r_spm [SPM_DEPTH];
    logic [31:0]   r_spm_q;
    logic [2:0]    r_load;
    logic [1:0]    r_lo;
    logic [TW-1:0] r_tmo;
    logic [31:0]   r_rdata;
    logic [1:0]    r_fault;
    logic [31:0]   r_mem_addr;
    logic          r_mem_we;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_wmask;

    logic          w_accept, w_ld_none, w_st_none, w_ld_ok, w_st_ok;
    logic          w_illegal, w_nop, w_misal, w_go_resp, w_is_st, w_in_spm;
    logic          w_spm_wr, w_spm_rd, w_tmo_hit;
    logic [1:0]    w_size, w_fault_cls;
    logic [31:0]   w_off, w_lane_data;
    logic [3:0]    w_lane_mask;
    logic [AW-1:0] w_idx;

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  f_extract = {{24{b[7]}}, b};
            3'b001:  f_extract = {{16{h[15]}}, h};
            3'b100:  f_extract = {24'h0, b};
            3'b101:  f_extract = {16'h0, h};
            default: f_extract = word;
        endcase
    endfunction

    // Classification, first match wins: illegal, NOP, misaligned, then SPM vs external.
    assign w_accept    = i_req_valid && (r_state == IDLE);
    assign w_ld_none   = (i_req_load == 3'b111);
    assign w_st_none   = (i_req_store == 3'b111);
    assign w_ld_ok     = i_req_load inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign w_st_ok     = i_req_store inside {3'b000, 3'b001, 3'b010};
    assign w_illegal   = (!w_ld_none && !w_st_none) || (!w_ld_none && !w_ld_ok) || (!w_st_none && !w_st_ok);
    assign w_nop       = w_ld_none && w_st_none;
    assign w_is_st     = !w_st_none;
    assign w_size      = w_is_st ? i_req_store[1:0] : i_req_load[1:0];
    assign w_misal     = ((w_size == 2'b01) && i_req_addr[0]) || ((w_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
    assign w_go_resp   = w_illegal || w_nop || w_misal;
    assign w_fault_cls = w_illegal ? 2'b11 : (w_nop ? 2'b00 : (w_misal ? 2'b01 : 2'b00));
    assign w_off       = i_req_addr - SPM_BASE;
    assign w_in_spm    = (i_req_addr >= SPM_BASE) && (w_off < SPM_BYTES);
    assign w_idx       = w_off[AW+1:2];
    assign w_spm_wr    = w_accept && !w_go_resp && w_in_spm && w_is_st;
    assign w_spm_rd    = w_accept && !w_go_resp && w_in_spm && !w_is_st;
    assign w_tmo_hit   = (r_tmo == TMO_LAST);

    always_comb begin
        w_lane_data = i_req_wdata;
        w_lane_mask = 4'b1111;
        case (i_req_store[1:0])
            2'b00: begin
                w_lane_data = {4{i_req_wdata[7:0]}};
                w_lane_mask = 4'b0001 << i_req_addr[1:0];
            end
            2'b01: begin
                w_lane_data = {2{i_req_wdata[15:0]}};
                w_lane_mask = 4'b0011 << i_req_addr[1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_spm_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lane_mask[b]) r_spm[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
            end
        end
        if (w_spm_rd) r_spm_q <= r_spm[w_idx];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        o_req_ready     = 1'b0;
        o_resp_valid    = 1'b0;
        o_mem_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (w_go_resp || (w_in_spm && w_is_st)) w_next = RESP;
                    else if (w_in_spm)                      w_next = SPM_RD;
                    else                                    w_next = MEM_REQ;
                end
            end
            SPM_RD: w_next = RESP;
            MEM_REQ: begin
                o_mem_req_valid = 1'b1;
                if (w_tmo_hit)            w_next = RESP;
                else if (i_mem_req_ready) w_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (i_mem_resp_valid || w_tmo_hit) w_next = RESP;
            end
            RESP: begin
                o_resp_valid = 1'b1;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_load      <= 3'b000;
            r_lo        <= 2'b00;
            r_tmo       <= '0;
            r_rdata     <= 32'h0;
            r_fault     <= 2'b00;
            r_mem_addr  <= 32'h0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 32'h0;
            r_mem_wmask <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_load      <= i_req_load;
                        r_lo        <= i_req_addr[1:0];
                        r_tmo       <= '0;
                        r_rdata     <= 32'h0;
                        r_fault     <= w_fault_cls;
                        r_mem_addr  <= {i_req_addr[31:2], 2'b00};
                        r_mem_we    <= w_is_st;
                        r_mem_wdata <= w_lane_data;
                        r_mem_wmask <= w_is_st ? w_lane_mask : 4'b0000;
                    end
                end
                SPM_RD: r_rdata <= f_extract(r_spm_q, r_lo, r_load);
                MEM_REQ: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (w_tmo_hit) r_fault <= 2'b10;
                end
                MEM_WAIT: begin
                    r_tmo <= r_tmo + TW'(1);
                    // A response arriving on the timeout cycle still wins.
                    if (i_mem_resp_valid) begin
                        r_fault <= i_mem_resp_err ? 2'b10 : 2'b00;
                        r_rdata <= (i_mem_resp_err || r_mem_we) ? 32'h0 : f_extract(i_mem_resp_rdata, r_lo, r_load);
                    end else if (w_tmo_hit) begin
                        r_fault <= 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy          = (r_state != IDLE);
    assign o_resp_rdata    = r_rdata;
    assign o_resp_fault    = r_fault;
    assign o_mem_req_addr  = r_mem_addr;
    assign o_mem_req_we    = r_mem_we;
    assign o_mem_req_wdata = r_mem_wdata;
    assign o_mem_req_wmask = r_mem_wmask;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard testbench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    localparam int TMO = 8;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101, NONE = 3'b111;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic [31:0] i_req_addr = 32'h0, i_req_wdata = 32'h0;
    logic [2:0]  i_req_load = 3'b111, i_req_store = 3'b111;
    logic        i_mem_req_ready = 1'b0, i_mem_resp_valid = 1'b0, i_mem_resp_err = 1'b0;
    logic [31:0] i_mem_resp_rdata = 32'h0;
    logic        o_req_ready, o_resp_valid, o_busy, o_mem_req_valid, o_mem_req_we;
    logic [31:0] o_resp_rdata, o_mem_req_addr, o_mem_req_wdata;
    logic [1:0]  o_resp_fault;
    logic [3:0]  o_mem_req_wmask;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  fault;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.SPM_BASE(32'h8000_8000), .SPM_DEPTH(1024), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_load(i_req_load), .i_req_store(i_req_store), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_fault(o_resp_fault), .o_busy(o_busy),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_req_addr(o_mem_req_addr),
        .o_mem_req_we(o_mem_req_we), .o_mem_req_wdata(o_mem_req_wdata), .o_mem_req_wmask(o_mem_req_wmask),
        .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_rdata(i_mem_resp_rdata), .i_mem_resp_err(i_mem_resp_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    // Every response pulse is matched against the oldest expectation.
    always @(negedge i_clk) begin
        if (o_resp_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp rdata=%h fault=%b", o_resp_rdata, o_resp_fault);
            end else begin
                mon_e = sb_q.pop_front();
                if (o_resp_rdata !== mon_e.rdata || o_resp_fault !== mon_e.fault) begin
                    errors++;
                    $display("FAIL resp got rdata=%h fault=%b exp rdata=%h fault=%b",
                             o_resp_rdata, o_resp_fault, mon_e.rdata, mon_e.fault);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] rdata, input logic [1:0] fault);
        exp_t e;
        e.rdata = rdata;
        e.fault = fault;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (o_req_ready !== 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready got %b exp 1", o_req_ready);
        end
    endtask

    task automatic drive(input logic [2:0] ld, input logic [2:0] st, input logic [31:0] addr, input logic [31:0] wdata);
        i_req_valid = 1'b1;
        i_req_load  = ld;
        i_req_store = st;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_req_load  = NONE;
        i_req_store = NONE;
    endtask

    // Local (SPM / fault / NOP) access: checks latency and that the bus stays quiet.
    task automatic do_req(input logic [2:0] ld, input logic [2:0] st, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_fault, input int exp_lat);
        int n;
        bit mem_seen;
        wait_ready();
        push_exp(exp_rdata, exp_fault);
        drive(ld, st, addr, wdata);
        n = 1;
        mem_seen = (o_mem_req_valid !== 1'b0);
        while (o_resp_valid !== 1'b1 && n < exp_lat + 20) begin
            @(negedge i_clk);
            n++;
            mem_seen |= (o_mem_req_valid !== 1'b0);
        end
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL latency addr=%h got %0d exp %0d", addr, n, exp_lat);
        end
        checks++;
        if (mem_seen) begin
            errors++;
            $display("FAIL local_no_bus addr=%h got mem_req_valid=1 exp 0", addr);
        end
    endtask

    task automatic ext_op(input logic [2:0] ld, input logic [2:0] st, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, input int rdly, input logic [31:0] rdata, input logic err,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_mask,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_fault);
        logic [31:0] wa;
        wa = addr & 32'hFFFF_FFFC;
        wait_ready();
        push_exp(exp_rdata, exp_fault);
        i_mem_req_ready = 1'b0;
        drive(ld, st, addr, wdata);
        for (int i = 0; i <= stall; i++) begin
            checks++;
            if (o_mem_req_valid !== 1'b1 || o_mem_req_addr !== wa || o_mem_req_we !== (st != NONE) ||
                o_mem_req_wmask !== exp_mask || (st != NONE && o_mem_req_wdata !== exp_wdata)) begin
                errors++;
                $display("FAIL ext_req cyc=%0d got v=%b a=%h we=%b m=%b d=%h exp v=1 a=%h m=%b d=%h", i,
                         o_mem_req_valid, o_mem_req_addr, o_mem_req_we, o_mem_req_wmask, o_mem_req_wdata,
                         wa, exp_mask, exp_wdata);
            end
            if (i == stall) i_mem_req_ready = 1'b1;
            @(negedge i_clk);
        end
        i_mem_req_ready = 1'b0;
        checks++;
        if (o_mem_req_valid !== 1'b0 || o_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ext_wait got mem_req_valid=%b resp_valid=%b exp 0 0", o_mem_req_valid, o_resp_valid);
        end
        repeat (rdly) @(negedge i_clk);
        i_mem_resp_valid = 1'b1;
        i_mem_resp_rdata = rdata;
        i_mem_resp_err   = err;
        @(negedge i_clk);
        i_mem_resp_valid = 1'b0;
        i_mem_resp_err   = 1'b0;
        checks++;
        if (o_resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL ext_resp_timing got resp_valid=%b exp 1", o_resp_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (o_req_ready !== 1'b1 || o_busy !== 1'b0 || o_resp_valid !== 1'b0 || o_mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b rv=%b mv=%b exp 1 0 0 0",
                     o_req_ready, o_busy, o_resp_valid, o_mem_req_valid);
        end
        checks++;
        if (o_resp_rdata !== 32'h0 || o_resp_fault !== 2'b00 || o_mem_req_addr !== 32'h0 ||
            o_mem_req_we !== 1'b0 || o_mem_req_wdata !== 32'h0 || o_mem_req_wmask !== 4'b0000) begin
            errors++;
            $display("FAIL reset_data got rd=%h f=%b a=%h we=%b d=%h m=%b exp all 0", o_resp_rdata, o_resp_fault,
                     o_mem_req_addr, o_mem_req_we, o_mem_req_wdata, o_mem_req_wmask);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_spm_word();
        do_req(NONE, SW, 32'h8000_8010, 32'hDEAD_BEEF, 32'h0, 2'b00, 1);
        do_req(LW, NONE, 32'h8000_8010, 32'h0, 32'hDEAD_BEEF, 2'b00, 2);
    endtask

    task automatic test_spm_byte();
        do_req(NONE, SW, 32'h8000_8010, 32'h0, 32'h0, 2'b00, 1);
        do_req(NONE, SB, 32'h8000_8013, 32'h1234_5680, 32'h0, 2'b00, 1);
        checks++;
        if (o_mem_req_wmask !== 4'b1000) begin
            errors++;
            $display("FAIL sb_wmask got %b exp 1000", o_mem_req_wmask);
        end
        do_req(LB,  NONE, 32'h8000_8013, 32'h0, 32'hFFFF_FF80, 2'b00, 2);
        do_req(LBU, NONE, 32'h8000_8013, 32'h0, 32'h0000_0080, 2'b00, 2);
        do_req(LHU, NONE, 32'h8000_8012, 32'h0, 32'h0000_8000, 2'b00, 2);
        do_req(LH,  NONE, 32'h8000_8012, 32'h0, 32'hFFFF_8000, 2'b00, 2);
        do_req(NONE, SW, 32'h8000_8020, 32'h0, 32'h0, 2'b00, 1);
        do_req(NONE, SH, 32'h8000_8022, 32'h1234_A5C3, 32'h0, 2'b00, 1);
        do_req(LW, NONE, 32'h8000_8020, 32'h0, 32'hA5C3_0000, 2'b00, 2);
    endtask

    task automatic test_bounds();
        do_req(NONE, SW, 32'h8000_8FFC, 32'h1122_3344, 32'h0, 2'b00, 1);
        do_req(LW, NONE, 32'h8000_8FFC, 32'h0, 32'h1122_3344, 2'b00, 2);
        ext_op(LW,  NONE, 32'h8000_9000, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, 32'h0, 4'b0000, 32'hCAFE_F00D, 2'b00);
        ext_op(LHU, NONE, 32'h8000_7FFE, 32'h0, 0, 1, 32'hABCD_1234, 1'b0, 32'h0, 4'b0000, 32'h0000_ABCD, 2'b00);
    endtask

    task automatic test_faults();
        do_req(LH,   NONE, 32'h8000_0001, 32'h0, 32'h0, 2'b01, 1);
        do_req(LW,   NONE, 32'h8000_8012, 32'h0, 32'h0, 2'b01, 1);
        do_req(NONE, SH,   32'h8000_8021, 32'hFFFF_FFFF, 32'h0, 2'b01, 1);
        do_req(NONE, SW,   32'h8000_8012, 32'hFFFF_FFFF, 32'h0, 2'b01, 1);
        do_req(LW,   NONE, 32'h8000_8010, 32'h0, 32'h8000_0000, 2'b00, 2);
        do_req(LW,   SW,   32'h8000_8010, 32'h0, 32'h0, 2'b11, 1);
        do_req(3'b011, NONE, 32'h8000_8010, 32'h0, 32'h0, 2'b11, 1);
        do_req(NONE, 3'b011, 32'h8000_8010, 32'h0, 32'h0, 2'b11, 1);
        do_req(NONE, NONE, 32'h8000_0000, 32'h0, 32'h0, 2'b00, 1);
    endtask

    task automatic test_ext_stall();
        ext_op(LW, NONE, 32'h8000_0004, 32'h0, 3, 1, 32'h1234_5678, 1'b0, 32'h0, 4'b0000, 32'h1234_5678, 2'b00);
    endtask

    task automatic test_ext_store();
        ext_op(NONE, SB, 32'h8000_0002, 32'h0000_00A5, 1, 0, 32'hFFFF_FFFF, 1'b0, 32'hA5A5_A5A5, 4'b0100, 32'h0, 2'b00);
        ext_op(NONE, SH, 32'h8000_0006, 32'h0000_BEEF, 0, 2, 32'hFFFF_FFFF, 1'b0, 32'hBEEF_BEEF, 4'b1100, 32'h0, 2'b00);
    endtask

    task automatic test_timeout();
        int n;
        for (int r = 0; r < 2; r++) begin
            wait_ready();
            push_exp(32'h0, 2'b10);
            i_mem_req_ready = r[0];
            drive(LW, NONE, 32'h8000_0100, 32'h0);
            n = 1;
            while (o_resp_valid !== 1'b1 && n < 40) begin
                @(negedge i_clk);
                n++;
            end
            checks++;
            if (n != TMO + 1) begin
                errors++;
                $display("FAIL timeout_latency ready=%0d got %0d exp %0d", r, n, TMO + 1);
            end
            checks++;
            if (o_mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_drop got mem_req_valid=%b exp 0", o_mem_req_valid);
            end
            i_mem_req_ready = 1'b0;
            @(negedge i_clk);
            i_mem_resp_valid = 1'b1;
            i_mem_resp_rdata = 32'hBAD0_BAD0;
            @(negedge i_clk);
            i_mem_resp_valid = 1'b0;
            checks++;
            if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL late_resp got resp_valid=%b ready=%b exp 0 1", o_resp_valid, o_req_ready);
            end
        end
    endtask

    task automatic test_ext_err();
        ext_op(LW, NONE, 32'h8000_0008, 32'h0, 0, 0, 32'h5555_5555, 1'b1, 32'h0, 4'b0000, 32'h0, 2'b10);
        ext_op(LB, NONE, 32'h8000_0003, 32'h0, 2, 0, 32'h80FF_FFFF, 1'b0, 32'h0, 4'b0000, 32'hFFFF_FF80, 2'b00);
    endtask

    task automatic test_reset_mid();
        wait_ready();
        i_mem_req_ready = 1'b1;
        drive(LW, NONE, 32'h8000_0200, 32'h0);
        @(negedge i_clk);
        i_mem_req_ready = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait got busy=%b mem_req_valid=%b exp 1 0", o_busy, o_mem_req_valid);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 1'b1 || o_busy !== 1'b0 || o_mem_req_valid !== 1'b0 || o_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got ready=%b busy=%b mv=%b rv=%b exp 1 0 0 0",
                     o_req_ready, o_busy, o_mem_req_valid, o_resp_valid);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_mem_resp_valid = 1'b1;
        i_mem_resp_rdata = 32'h0BAD_0BAD;
        @(negedge i_clk);
        i_mem_resp_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got resp_valid=%b ready=%b exp 0 1", o_resp_valid, o_req_ready);
        end
        do_req(LW, NONE, 32'h8000_8FFC, 32'h0, 32'h1122_3344, 2'b00, 2);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        test_reset();
        test_spm_word();
        test_spm_byte();
        test_bounds();
        test_faults();
        test_ext_stall();
        test_ext_store();
        test_timeout();
        test_ext_err();
        test_reset_mid();
        repeat (3) @(negedge i_clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_resp got %0d outstanding exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
